// File: rtl/watchdog_pkg.sv
// watchdog_pkg: state encoding, default parameters and width helpers shared
// by the watchdog controller and its kick decoder.
package watchdog_pkg;

  typedef logic [1:0] wd_state_t;

  localparam wd_state_t ST_HOLD = 2'd0;
  localparam wd_state_t ST_RUN  = 2'd1;
  localparam wd_state_t ST_DIS  = 2'd2;

  localparam int         DEF_TIMEOUT     = 8;
  localparam int         DEF_HOLD        = 8;
  localparam logic [4:0] DEF_KICK_ADDR_U = 5'b11000;
  localparam int         DEF_TRIP_W      = 4;

  function automatic int wd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int wd_clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/watchdog_kick_decode.sv
// watchdog_kick_decode: decodes 68k accesses to the kick window ($300001)
// and turns a write access into a single-cycle kick, however long the
// strobe is held. Also reports a read of the same window for the status port.
module watchdog_kick_decode
  import watchdog_pkg::*;
#(
  parameter logic [4:0] KICK_ADDR_U = DEF_KICK_ADDR_U
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lds_n,
  input  logic       rw,
  input  logic       a23,
  input  logic       a22,
  input  logic [4:0] addr_u,
  output logic       kdec,
  output logic       rdec,
  output logic       kick
);

  logic hit;
  logic kdec_q;

  assign hit  = ~lds_n & ~a23 & ~a22 & (addr_u == KICK_ADDR_U);
  assign kdec = hit & ~rw;
  assign rdec = hit & rw;

  // Remember last cycle's write decode so only the leading edge kicks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kdec_q <= 1'b0;
    end else begin
      kdec_q <= kdec;
    end
  end

  assign kick = kdec & ~kdec_q;

endmodule

// File: rtl/watchdog_ctrl.sv
// watchdog_ctrl: 68k bus watchdog. Holds nRESET/nHALT low for HOLD ticks
// after power-on or a timeout, then expects a write to $300001 at least
// every TIMEOUT ticks. Counts timeouts in a saturating trip counter.
// Optional build macro WATCHDOG_STATUS_EN adds a read-back status port
// (STATUS_OE/STATUS_DATA) on reads of the kick window.
//
// state | meaning
// HOLD  | reset pulse in progress, nRESET low, kicks and disable ignored
// RUN   | counting towards timeout, kicks restart the count
// DIS   | watchdog parked by WD_DISABLE, counter held at zero
module watchdog_ctrl
  import watchdog_pkg::*;
#(
  parameter int         TIMEOUT     = DEF_TIMEOUT,
  parameter int         HOLD        = DEF_HOLD,
  parameter logic [4:0] KICK_ADDR_U = DEF_KICK_ADDR_U,
  parameter int         TRIP_W      = DEF_TRIP_W
) (
  input  logic              WDCLK,
  input  logic              nRST,
  input  logic              nLDS,
  input  logic              RW,
  input  logic              A23I,
  input  logic              A22I,
  input  logic [4:0]        M68K_ADDR_U,
  input  logic              WD_DISABLE,
  output logic              nRESET,
  output logic              nHALT,
  output logic              WDTRIP,
  output logic [TRIP_W-1:0] TRIP_CNT
`ifdef WATCHDOG_STATUS_EN
  ,
  output logic              STATUS_OE,
  output logic [7:0]        STATUS_DATA
`endif
);

  localparam int CW = wd_clog2(wd_max(TIMEOUT, HOLD));
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [TRIP_W-1:0] TRIP_MAX = {TRIP_W{1'b1}};

  wd_state_t         state;
  logic [CW-1:0]     cnt;
  logic [TRIP_W-1:0] trip_cnt;
  logic              wdtrip;
  logic              kdec;
  logic              rdec;
  logic              kick;
  logic              unused_kdec;

  watchdog_kick_decode #(
    .KICK_ADDR_U(KICK_ADDR_U)
  ) u_kick_decode (
    .clk   (WDCLK),
    .rst_n (nRST),
    .lds_n (nLDS),
    .rw    (RW),
    .a23   (A23I),
    .a22   (A22I),
    .addr_u(M68K_ADDR_U),
    .kdec  (kdec),
    .rdec  (rdec),
    .kick  (kick)
  );

  // The edge-detected kick is all the FSM needs; the raw decode is spare.
  assign unused_kdec = kdec;

  // Main sequencer: reset pulse, timeout counting, disable parking, trip count.
  always_ff @(posedge WDCLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ST_HOLD;
      cnt      <= '0;
      trip_cnt <= '0;
      wdtrip   <= 1'b0;
    end else begin
      wdtrip <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (kick) begin
            // A kick on the final tick still rescues the system.
            cnt <= '0;
            if (WD_DISABLE) state <= ST_DIS;
          end else if (cnt == TO_LAST) begin
            state  <= ST_HOLD;
            cnt    <= '0;
            wdtrip <= 1'b1;
            if (trip_cnt != TRIP_MAX) trip_cnt <= trip_cnt + 1'b1;
          end else if (WD_DISABLE) begin
            state <= ST_DIS;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DIS: begin
          cnt <= '0;
          if (!WD_DISABLE) state <= ST_RUN;
        end
        default: begin
          state <= ST_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  // nRST gates the reset line directly so it drops the instant reset asserts.
  assign nRESET   = nRST & (state != ST_HOLD);
  assign nHALT    = nRESET;
  assign WDTRIP   = wdtrip;
  assign TRIP_CNT = trip_cnt;

`ifdef WATCHDOG_STATUS_EN
  assign STATUS_OE   = rdec;
  assign STATUS_DATA = {state, 2'b00, 4'(trip_cnt)};
`else
  logic unused_rdec;
  assign unused_rdec = rdec;
`endif

endmodule

// File: tb/tb_watchdog_ctrl.sv
// tb_watchdog_ctrl: directed plus randomized stimulus for watchdog_ctrl,
// checked every tick against a behavioural model through a scoreboard queue.
module tb_watchdog_ctrl;

  localparam int         TIMEOUT = 8;
  localparam int         HOLD    = 8;
  localparam logic [4:0] KICK    = 5'b11000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lds_n;
  logic       rw;
  logic       a23;
  logic       a22;
  logic [4:0] addr_u;
  logic       dis;
  logic       nreset;
  logic       nhalt;
  logic       wdtrip;
  logic [3:0] trip_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  watchdog_ctrl dut (
    .WDCLK      (clk),
    .nRST       (rst_n),
    .nLDS       (lds_n),
    .RW         (rw),
    .A23I       (a23),
    .A22I       (a22),
    .M68K_ADDR_U(addr_u),
    .WD_DISABLE (dis),
    .nRESET     (nreset),
    .nHALT      (nhalt),
    .WDTRIP     (wdtrip),
    .TRIP_CNT   (trip_cnt)
  );

  always #5 clk = ~clk;

  // Expected {nRESET, nHALT, WDTRIP, TRIP_CNT} after each rising edge.
  logic [6:0] exp_q[$];

  // Behavioural model: ticks left in the reset pulse, ticks since the last
  // restart, a parked flag and a trip tally.
  int hold_left = HOLD;
  int since     = 0;
  int trips     = 0;
  bit parked    = 0;
  bit prev_wr   = 0;

  always @(posedge clk) begin
    bit wr;
    bit kicked;
    bit tripped;
    bit line;
    tripped = 0;
    cyc++;
    if (!rst_n) begin
      hold_left = HOLD;
      since     = 0;
      trips     = 0;
      parked    = 0;
      prev_wr   = 0;
    end else begin
      wr      = !lds_n && !rw && !a23 && !a22 && (addr_u == KICK);
      kicked  = wr && !prev_wr;
      prev_wr = wr;
      if (hold_left > 0) begin
        hold_left--;
      end else if (parked) begin
        since = 0;
        if (!dis) parked = 0;
      end else if (kicked) begin
        since = 0;
        if (dis) parked = 1;
      end else if (since == TIMEOUT - 1) begin
        tripped   = 1;
        hold_left = HOLD;
        since     = 0;
        if (trips < 15) trips++;
      end else if (dis) begin
        parked = 1;
        since  = 0;
      end else begin
        since++;
      end
    end
    line = rst_n && (hold_left == 0);
    exp_q.push_back({line, line, tripped, 4'(trips)});
  end

  // Monitor: compare the DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    logic [6:0] e;
    logic [6:0] a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {nreset, nhalt, wdtrip, trip_cnt};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs cyc %0d {nRESET,nHALT,WDTRIP,TRIP_CNT} got %b exp %b", cyc, a, e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    lds_n  = 1'b1;
    rw     = 1'b1;
    a23    = 1'b0;
    a22    = 1'b0;
    addr_u = 5'd0;
  endtask

  task automatic access(input bit rd, input logic [4:0] a, input bit hi23,
                        input bit hi22, input int n);
    lds_n  = 1'b0;
    rw     = rd;
    a23    = hi23;
    a22    = hi22;
    addr_u = a;
    step(n);
    bus_idle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    step(n);
    rst_n = 1'b1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dis   = 1'b0;
    bus_idle();
    #1;
    check("nRESET during reset", {7'd0, nreset}, 8'd0);
    step(3);
    rst_n = 1'b1;

    // Free-running: two full trip cycles with no kicks.
    step(40);

    // Regular kicks every 6 ticks keep the system alive.
    do_reset(2);
    step(HOLD);
    for (int i = 0; i < 17; i++) begin
      access(1'b0, KICK, 1'b0, 1'b0, 1);
      step(5);
    end

    // Long strobe counts as a single kick.
    access(1'b0, KICK, 1'b0, 1'b0, 20);
    step(30);

    // Kick on the last tick before timeout, then a kick during HOLD.
    do_reset(2);
    step(HOLD + TIMEOUT - 1);
    access(1'b0, KICK, 1'b0, 1'b0, 1);
    step(TIMEOUT + 2);
    access(1'b0, KICK, 1'b0, 1'b0, 2);
    step(12);

    // Disable parks the watchdog; release lets it time out again.
    do_reset(2);
    step(HOLD + 2);
    dis = 1'b1;
    step(50);
    dis = 1'b0;
    step(20);

    // Reads and off-window writes must not kick.
    access(1'b1, KICK, 1'b0, 1'b0, 2);
    access(1'b0, KICK, 1'b1, 1'b0, 2);
    access(1'b0, 5'b11001, 1'b0, 1'b0, 2);
    step(20);

    // Enough trips to saturate the counter.
    step(17 * (HOLD + TIMEOUT) + 10);

    // Async reset mid-RUN with one trip recorded.
    do_reset(2);
    step(HOLD + TIMEOUT + HOLD + 4);
    check("nRESET in RUN", {7'd0, nreset}, 8'd1);
    check("TRIP_CNT before reset", {4'd0, trip_cnt}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("nRESET async fall", {7'd0, nreset}, 8'd0);
    check("nHALT async fall", {7'd0, nhalt}, 8'd0);
    check("TRIP_CNT async clear", {4'd0, trip_cnt}, 8'd0);
    step(2);
    rst_n = 1'b1;
    step(20);

    // Randomized traffic.
    for (int op = 0; op < 300; op++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: step($urandom_range(1, 12));
        4, 5: access(1'b0, KICK, 1'b0, 1'b0, $urandom_range(1, 4));
        6: access(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) != 0) ? KICK : 5'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom_range(1, 3));
        7: begin
          dis = 1'b1;
          step($urandom_range(1, 20));
          dis = 1'b0;
        end
        default: begin
          if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3));
          else step(1);
        end
      endcase
    end

    step(2);
    check("scoreboard drained", 8'(exp_q.size() > 1), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
